// File: rtl/hdb3_encode_ctrl.sv
// HDB3 line-code encoder: delays the NRZ stream by N_ZERO strobes so each zero run can be
// rewritten as 000V / B00V before it reaches the alternate-mark-inversion output stage.
module hdb3_encode_ctrl #(
  parameter int unsigned N_ZERO = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_valid,
  input  logic din,
  output logic P,
  output logic N,
  output logic dout_valid,
  output logic v_mark,
  output logic b_mark
);

  localparam int unsigned CntW = (N_ZERO > 1) ? $clog2(N_ZERO) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N_ZERO - 1);

  typedef enum logic [1:0] {
    SymZero = 2'b00,
    SymOne  = 2'b01,
    SymV    = 2'b10,
    SymB    = 2'b11
  } sym_e;

  sym_e            sym_q [N_ZERO];
  sym_e            sym_d [N_ZERO];
  logic [CntW-1:0] zero_cnt_q, zero_cnt_d;
  logic            parity_q, parity_d;
  logic            last_pol_q, last_pol_d;
  sym_e            out_sym;
  logic            p_d, n_d, valid_d, v_d, b_d;

  always_comb begin
    sym_d      = sym_q;
    zero_cnt_d = zero_cnt_q;
    parity_d   = parity_q;
    last_pol_d = last_pol_q;
    out_sym    = SymZero;
    p_d        = 1'b0;
    n_d        = 1'b0;
    valid_d    = 1'b0;
    v_d        = 1'b0;
    b_d        = 1'b0;

    if (din_valid) begin
      out_sym = sym_q[N_ZERO-1];
      valid_d = 1'b1;
      for (int unsigned i = 1; i < N_ZERO; i++) begin
        sym_d[i] = sym_q[i-1];
      end

      if (din) begin
        sym_d[0]   = SymOne;
        zero_cnt_d = '0;
        parity_d   = ~parity_q;
      end else if (zero_cnt_q == CntLast) begin
        sym_d[0] = SymV;
        // Post-shift tail holds the first zero of the run, never the symbol being emitted.
        if (!parity_q) begin
          sym_d[N_ZERO-1] = SymB;
        end
        zero_cnt_d = '0;
        parity_d   = 1'b0;
      end else begin
        sym_d[0]   = SymZero;
        zero_cnt_d = zero_cnt_q + 1'b1;
      end

      unique case (out_sym)
        SymOne, SymB: begin
          p_d        = last_pol_q;
          n_d        = ~last_pol_q;
          last_pol_d = ~last_pol_q;
          b_d        = (out_sym == SymB);
        end
        SymV: begin
          p_d = ~last_pol_q;
          n_d = last_pol_q;
          v_d = 1'b1;
        end
        SymZero: begin
          p_d = 1'b0;
          n_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_ZERO; i++) begin
        sym_q[i] <= SymZero;
      end
      zero_cnt_q <= '0;
      parity_q   <= 1'b0;
      last_pol_q <= 1'b1;
      P          <= 1'b0;
      N          <= 1'b0;
      dout_valid <= 1'b0;
      v_mark     <= 1'b0;
      b_mark     <= 1'b0;
    end else begin
      sym_q      <= sym_d;
      zero_cnt_q <= zero_cnt_d;
      parity_q   <= parity_d;
      last_pol_q <= last_pol_d;
      P          <= p_d;
      N          <= n_d;
      dout_valid <= valid_d;
      v_mark     <= v_d;
      b_mark     <= b_d;
    end
  end

endmodule

// File: tb/tb_hdb3_encode_ctrl.sv
// Bench for hdb3_encode_ctrl: table-driven scenarios through a scoreboard queue, a mid-run
// reset sequence, and a random stream decoded back from the rails.
module tb_hdb3_encode_ctrl;

  localparam int unsigned NZ = 4;
  localparam int NRand = 10000;
  localparam int NFlush = 2 * NZ;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din_valid = 1'b0;
  logic din = 1'b0;
  logic p, n, dout_valid, v_mark, b_mark;

  hdb3_encode_ctrl #(.N_ZERO(NZ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .P          (p),
    .N          (n),
    .dout_valid (dout_valid),
    .v_mark     (v_mark),
    .b_mark     (b_mark)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic p;
    logic n;
    logic b;
    logic v;
  } exp_t;

  typedef struct {
    int          len;
    int          gap;
    logic [15:0] din;
    logic [15:0] ep;
    logic [15:0] en;
    logic [15:0] eb;
    logic [15:0] ev;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   dout_cnt = 0;
  bit   rand_mode = 1'b0;

  // Random-mode loopback decoder state
  logic rand_din [NRand + NFlush];
  logic dec      [NRand + NFlush];
  int   out_idx;
  int   zrun;
  logic prev_pol;
  logic last_vpol;
  bit   have_v;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (!dout_valid) begin
        chk("idle_outputs_zero", {p, n, v_mark, b_mark}, 0);
      end else begin
        dout_cnt++;
        chk("rails_exclusive", int'(p & n), 0);
        if (!rand_mode) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("symbol_rails_marks", {p, n, b_mark, v_mark}, int'(e));
          end
        end else begin
          if (out_idx < int'(NZ)) begin
            chk("prefill_zero", {p, n}, 0);
          end else begin
            int j;
            j = out_idx - int'(NZ);
            if (p | n) begin
              if (n == prev_pol) begin
                chk("v_mark_on_violation", int'(v_mark), 1);
                if (have_v) chk("v_alternates", int'(n != last_vpol), 1);
                last_vpol = n;
                have_v = 1'b1;
                for (int m = 0; m < int'(NZ); m++) begin
                  if (j - m >= 0) dec[j-m] = 1'b0;
                end
              end else begin
                chk("v_mark_on_mark", int'(v_mark), 0);
                dec[j] = 1'b1;
              end
              prev_pol = n;
              zrun = 0;
            end else begin
              dec[j] = 1'b0;
              zrun++;
              chk("zero_run_bound", int'(zrun <= int'(NZ) - 1), 1);
            end
          end
          out_idx++;
        end
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    din = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("reset_outputs", {p, n, dout_valid, v_mark, b_mark}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dout_cnt = 0;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the sampling edge.
  task automatic strobe(input logic d, input exp_t e);
    din_valid = 1'b1;
    din = d;
    if (!rand_mode) exp_q.push_back(e);
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int strobes);
    idle(3);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_dout_count"}, dout_cnt, strobes);
  endtask

  vec_t vecs[4];

  initial begin
    exp_t e;
    int   bad;
    int   first_bad;

    // Bit k of each field belongs to strobe k (LSB first).
    vecs[0] = '{len: 12, gap: 0, din: 16'h0000, ep: 16'h0090, en: 16'h0900,
                eb: 16'h0110, ev: 16'h0880};
    vecs[1] = '{len: 9, gap: 0, din: 16'h0001, ep: 16'h0110, en: 16'h0000,
                eb: 16'h0000, ev: 16'h0100};
    vecs[2] = '{len: 11, gap: 0, din: 16'h0043, ep: 16'h0250, en: 16'h0420,
                eb: 16'h0040, ev: 16'h0200};
    vecs[3] = '{len: 9, gap: 3, din: 16'h0001, ep: 16'h0110, en: 16'h0000,
                eb: 16'h0000, ev: 16'h0100};

    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int k = 0; k < vecs[s].len; k++) begin
        e = '{p: vecs[s].ep[k], n: vecs[s].en[k], b: vecs[s].eb[k], v: vecs[s].ev[k]};
        strobe(vecs[s].din[k], e);
        if (vecs[s].gap > 0) idle($urandom_range(0, vecs[s].gap));
      end
      drain($sformatf("table%0d", s), vecs[s].len);
    end

    // Mid-run reset: ONE pulse is on the outputs when rst_n drops.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      e = '0;
      if (k >= 4) e = '{p: (k % 2 == 0), n: (k % 2 == 1), b: 1'b0, v: 1'b0};
      strobe((k < 5), e);
    end
    chk("pre_reset_valid", {dout_valid, n}, 3);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {p, n, dout_valid, v_mark, b_mark}, 0);
    exp_q.delete();
    idle(1);
    rst_n = 1'b1;
    dout_cnt = 0;
    idle(1);
    for (int k = 0; k < 5; k++) begin
      e = '0;
      if (k == 4) e = '{p: 1'b1, n: 1'b0, b: 1'b0, v: 1'b0};
      strobe((k == 0), e);
    end
    drain("post_reset", 5);

    // Random stream decoded from the rails.
    do_reset();
    out_idx = 0;
    zrun = 0;
    prev_pol = 1'b1;
    last_vpol = 1'b0;
    have_v = 1'b0;
    for (int k = 0; k < NRand + NFlush; k++) begin
      rand_din[k] = (k < NRand) ? ($urandom_range(0, 2) == 0) : 1'b0;
      dec[k] = 1'b0;
    end
    rand_mode = 1'b1;
    for (int k = 0; k < NRand + NFlush; k++) begin
      strobe(rand_din[k], '0);
      if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("rand_dout_count", dout_cnt, NRand + NFlush);
    bad = 0;
    first_bad = -1;
    for (int k = 0; k < NRand; k++) begin
      if (dec[k] !== rand_din[k]) begin
        if (first_bad < 0) first_bad = k;
        bad++;
      end
    end
    chk("rand_decode_mismatches", bad, 0);
    if (bad != 0) $display("  first decode error at bit %0d", first_bad);
    rand_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
